// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the dCPU register file and its pending-write scoreboard.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_ADDR = 0;

  function automatic int addr_width(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: decode claims set, writeback retires clear, with a live busy count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int AW       = addr_width(NREG),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rstd,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  output logic            claim_ok,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     n_inc;
  logic [AW:0]     n_dec;
  logic [AW:0]     cnt_nxt;

  // A WAW claim is refused so decode stalls until the old producer retires.
  assign claim_ok = claim_en & ~busy[claim_addr];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    n_inc   = '0;
    n_dec   = '0;
    if (claim_ok && !(ZERO_REG && (claim_addr == AW'(ZERO_ADDR))))
      set_vec[claim_addr] = 1'b1;
    if (wr0_en) clr_vec[wr0_addr] = 1'b1;
    if (wr1_en) clr_vec[wr1_addr] = 1'b1;
    // Set after clear: a same-edge claim names the new producer.
    busy_nxt = set_vec | (busy & ~clr_vec);
    if (ZERO_REG) busy_nxt[ZERO_ADDR] = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (busy_nxt[i] && !busy[i]) n_inc = n_inc + CNT_ONE;
      if (!busy_nxt[i] && busy[i]) n_dec = n_dec + CNT_ONE;
    end
    cnt_nxt = busy_cnt + n_inc - n_dec;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with ALU and load write ports, optional write bypass,
// hardwired-zero r0 and an integrated pending-write scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int AW       = addr_width(NREG),
  parameter int NRD      = NRD_DEF,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [XLEN-1:0]   wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [XLEN-1:0]   wr1_data,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_ok,
  output logic [AW:0]       busy_cnt,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wr0_ok;
  logic            wr1_ok;

  assign wr0_ok = wr0_en && !(ZERO_REG && (wr0_addr == AW'(ZERO_ADDR)));
  assign wr1_ok = wr1_en && !(ZERO_REG && (wr1_addr == AW'(ZERO_ADDR)));

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rstd       (rstd),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .claim_ok   (claim_ok),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic            is_zero;
    logic            hit0;
    logic            hit1;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[g*AW +: AW];

    // A forwarded value is the final one, so it is never reported busy.
    always_comb begin
      is_zero = ZERO_REG && (a == AW'(ZERO_ADDR));
      hit1    = BYPASS && wr1_en && (wr1_addr == a) && !is_zero;
      hit0    = BYPASS && wr0_en && (wr0_addr == a) && !is_zero;
      if (is_zero) begin
        d = '0;
        b = 1'b0;
      end else if (hit1) begin
        d = wr1_data;
        b = 1'b0;
      end else if (hit0) begin
        d = wr0_data;
        b = 1'b0;
      end else begin
        d = regs[a];
        b = busy[a];
      end
    end

    assign rd_data[g*XLEN +: XLEN] = d;
    assign rd_busy[g]              = b;
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised scoreboard bench for reg_file_sb, bypass and non-bypass builds side by side.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic              clk = 1'b0;
  logic              rstd = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic              wr0_en = 1'b0, wr1_en = 1'b0, claim_en = 1'b0;
  logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0, claim_addr = '0, dbg_addr = '0;
  logic [XLEN-1:0]   wr0_data = '0, wr1_data = '0;

  logic [NRD*XLEN-1:0] rd_data, nb_rd_data;
  logic [NRD-1:0]      rd_busy, nb_rd_busy;
  logic                claim_ok, nb_claim_ok;
  logic [AW:0]         busy_cnt, nb_busy_cnt;
  logic [XLEN-1:0]     dbg_data, nb_dbg_data;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .rstd(rstd), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy_cnt(busy_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nb (
    .clk(clk), .rstd(rstd), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(nb_claim_ok),
    .busy_cnt(nb_busy_cnt), .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data));

  // Clock / reset
  always #5 clk = ~clk;

  // Expected response for one cycle; both builds share claim/count/debug expectations.
  typedef struct packed {
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD*XLEN-1:0] nb_rd_data;
    logic [NRD-1:0]      nb_rd_busy;
    logic                claim_ok;
    logic [AW:0]         busy_cnt;
    logic [XLEN-1:0]     dbg_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: architectural register contents and pending flags.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic void model_read(input int a, input bit byp,
                                     output logic [XLEN-1:0] d, output logic b);
    if (a == 0) begin
      d = '0; b = 1'b0;
    end else if (byp && wr1_en && int'(wr1_addr) == a) begin
      d = wr1_data; b = 1'b0;
    end else if (byp && wr0_en && int'(wr0_addr) == a) begin
      d = wr0_data; b = 1'b0;
    end else begin
      d = m_mem[a]; b = m_busy[a];
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   cnt = 0;
    for (int p = 0; p < NRD; p++) begin
      logic [XLEN-1:0] d;
      logic            b;
      model_read(int'(rd_addr[p*AW +: AW]), 1'b1, d, b);
      e.rd_data[p*XLEN +: XLEN] = d;
      e.rd_busy[p] = b;
      model_read(int'(rd_addr[p*AW +: AW]), 1'b0, d, b);
      e.nb_rd_data[p*XLEN +: XLEN] = d;
      e.nb_rd_busy[p] = b;
    end
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    e.claim_ok = claim_en && !m_busy[claim_addr];
    e.busy_cnt = (AW+1)'(cnt);
    e.dbg_data = m_mem[dbg_addr];
    return e;
  endfunction

  function automatic void model_edge();
    bit acc = claim_en && !m_busy[claim_addr];
    if (wr0_en) begin
      if (wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
      m_busy[wr0_addr] = 1'b0;
    end
    if (wr1_en) begin
      if (wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
      m_busy[wr1_addr] = 1'b0;
    end
    if (acc && claim_addr != 0) m_busy[claim_addr] = 1'b1;
  endfunction

  // Driver: one call = one clock cycle of stimulus.
  task automatic drive(input bit rn, input int r0a, input int r1a,
                       input bit w0e, input int w0a, input logic [XLEN-1:0] w0d,
                       input bit w1e, input int w1a, input logic [XLEN-1:0] w1d,
                       input bit ce, input int ca, input int da);
    @(posedge clk);
    #1;
    rstd       = rn;
    rd_addr    = {AW'(r1a), AW'(r0a)};
    wr0_en     = w0e; wr0_addr = AW'(w0a); wr0_data = w0d;
    wr1_en     = w1e; wr1_addr = AW'(w1a); wr1_data = w1d;
    claim_en   = ce;  claim_addr = AW'(ca);
    dbg_addr   = AW'(da);
    if (!rn) model_clear();
    exp_q.push_back(model_outputs());
    if (rn) model_edge();
  endtask

  task automatic idle(input int r0a, input int r1a, input int da);
    drive(1'b1, r0a, r1a, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, da);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rd_data",     64'(rd_data),     64'(e.rd_data));
      check("rd_busy",     64'(rd_busy),     64'(e.rd_busy));
      check("nb_rd_data",  64'(nb_rd_data),  64'(e.nb_rd_data));
      check("nb_rd_busy",  64'(nb_rd_busy),  64'(e.nb_rd_busy));
      check("claim_ok",    64'(claim_ok),    64'(e.claim_ok));
      check("nb_claim_ok", 64'(nb_claim_ok), 64'(e.claim_ok));
      check("busy_cnt",    64'(busy_cnt),    64'(e.busy_cnt));
      check("nb_busy_cnt", 64'(nb_busy_cnt), 64'(e.busy_cnt));
      check("dbg_data",    64'(dbg_data),    64'(e.dbg_data));
      check("nb_dbg_data", 64'(nb_dbg_data), 64'(e.dbg_data));
    end
  end

  initial begin
    model_clear();
    // Reset state, with a claim presented during reset
    drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, 0);
    drive(1'b0, 5, 3, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 3, 5);
    // T1: write r5, then reset with a pending write and claim
    drive(1'b1, 1, 2, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0, 1'b0, 0, 5);
    idle(5, 0, 5);
    drive(1'b0, 1, 2, 1'b1, 5, 32'h77, 1'b0, 0, '0, 1'b1, 5, 5);
    idle(5, 5, 5);
    // T2: r0 ignores writes and claims
    drive(1'b1, 0, 1, 1'b1, 0, 32'h1234, 1'b0, 0, '0, 1'b0, 0, 0);
    drive(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 0, 0);
    idle(0, 0, 0);
    // T3: dual write to r7, port 1 wins and is forwarded
    drive(1'b1, 7, 7, 1'b1, 7, 32'h11, 1'b1, 7, 32'h22, 1'b0, 0, 7);
    idle(7, 0, 7);
    // T4: claim r3, refused WAW claim, retire via port 1
    drive(1'b1, 3, 0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 3, 3);
    drive(1'b1, 3, 0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 3, 3);
    drive(1'b1, 2, 3, 1'b0, 0, '0, 1'b1, 3, 32'h55, 1'b0, 0, 3);
    idle(3, 0, 3);
    // T5: claim r2, then same-edge claim and write on r9
    drive(1'b1, 2, 9, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 2, 9);
    drive(1'b1, 2, 1, 1'b1, 9, 32'h99, 1'b0, 0, '0, 1'b1, 9, 9);
    idle(9, 2, 9);
    // T6: same-cycle read of r4 differs between the builds
    drive(1'b1, 1, 4, 1'b1, 4, 32'hA5, 1'b0, 0, '0, 1'b0, 0, 4);
    idle(4, 4, 4);
    // Random traffic, addresses concentrated to provoke collisions
    for (int n = 0; n < 600; n++) begin
      int hi = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      drive(($urandom_range(0, 99) != 0),
            $urandom_range(0, hi), $urandom_range(0, hi),
            ($urandom_range(0, 2) == 0), $urandom_range(0, hi), $urandom,
            ($urandom_range(0, 2) == 0), $urandom_range(0, hi), $urandom,
            ($urandom_range(0, 1) == 0), $urandom_range(0, hi), $urandom_range(0, hi));
    end
    idle(0, 0, 0);
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
